// File: rtl/fb_filter_engine_pkg.sv
// Shared definitions for the framebuffer filter engine.
//   state_t   : engine FSM states (IDLE, READ, WRITE, DONE)
//   MODE_*    : pixel transform selections on the 2-bit mode input
//   PIXEL_W   : framebuffer pixel width, packed {R,G,B} at 4 bits each
package fb_filter_engine_pkg;

  localparam int PIXEL_W = 12;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_THR  = 2'b10;
  localparam logic [1:0] MODE_GRAY = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fb_filter_engine_xform.sv
// fb_pixel_xform: combinational per-pixel transform.
//   mode   (in,  2)        : MODE_PASS / MODE_INV / MODE_THR / MODE_GRAY
//   pixel  (in,  PIXEL_W)  : source pixel {R,G,B}
//   result (out, PIXEL_W)  : transformed pixel
// Optional feature macro: FB_FILTER_GRAYSCALE_EN. When undefined, MODE_GRAY
// falls back to pass-through and no grayscale logic exists.
module fb_pixel_xform
  import fb_filter_engine_pkg::*;
#(
  parameter int THRESH = 23
) (
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] pixel,
  output logic [PIXEL_W-1:0] result
);

  // Channel sum is at most 45, so 6 bits hold it without overflow.
  function automatic logic [PIXEL_W-1:0] thresh_fn(input logic [PIXEL_W-1:0] p);
    logic [5:0] sum;
    sum = {2'b00, p[11:8]} + {2'b00, p[7:4]} + {2'b00, p[3:0]};
    return (int'(sum) >= THRESH) ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
  endfunction

`ifdef FB_FILTER_GRAYSCALE_EN
  // Luma approximation (R + 2G + B) / 4; the sum peaks at 60 so 6 bits suffice.
  function automatic logic [PIXEL_W-1:0] gray_fn(input logic [PIXEL_W-1:0] p);
    logic [5:0] y_sum;
    logic [3:0] y;
    y_sum = {2'b00, p[11:8]} + {1'b0, p[7:4], 1'b0} + {2'b00, p[3:0]};
    y     = y_sum[5:2];
    return {y, y, y};
  endfunction
`endif

  always_comb begin
    result = pixel;
    case (mode)
      MODE_PASS: result = pixel;
      MODE_INV:  result = pixel ^ {PIXEL_W{1'b1}};
      MODE_THR:  result = thresh_fn(pixel);
`ifdef FB_FILTER_GRAYSCALE_EN
      MODE_GRAY: result = gray_fn(pixel);
`else
      MODE_GRAY: result = pixel;
`endif
      default:   result = pixel;
    endcase
  end

endmodule

// File: rtl/fb_filter_engine.sv
// fb_filter_engine: walks the framebuffer once per start request, reading
// each pixel, transforming it and writing it back in place (2 cycles/pixel).
//   clk        (in)          : system clock, shared with the framebuffer RAM
//   reset      (in)          : asynchronous, active-low
//   start      (in)          : one-cycle frame request, honoured only in IDLE
//   abort      (in)          : ends a pass in progress without a done pulse
//   mode       (in,  2)      : transform select, latched at start
//   busy       (out)         : high in READ and WRITE
//   done       (out)         : one-cycle completion pulse
//   mem_addr   (out, ADDR_W) : framebuffer address
//   mem_rdata  (in,  12)     : RAM read data, one cycle after the address
//   mem_wdata  (out, 12)     : transformed pixel, zero outside WRITE
//   mem_wen    (out)         : RAM write enable
// Optional feature macro: FB_FILTER_GRAYSCALE_EN (grayscale in mode 11).
module fb_filter_engine
  import fb_filter_engine_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int THRESH = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       mem_rdata,
  output logic [11:0]       mem_wdata,
  output logic              mem_wen
);

  localparam int unsigned      NPIX      = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  cnt, cnt_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic [PIXEL_W-1:0] xf_pixel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= MODE_PASS;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
    end
  end

  // The counter is parked at 0 whenever the FSM heads back to IDLE, so the
  // address output reads 0 in IDLE without extra muxing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start && !abort) begin
          mode_nxt  = mode;
          state_nxt = READ;
        end
      end
      READ: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LAST_ADDR) begin
          state_nxt = DONE;
        end else begin
          state_nxt = READ;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  fb_pixel_xform #(
    .THRESH (THRESH)
  ) u_xform (
    .mode   (mode_q),
    .pixel  (mem_rdata),
    .result (xf_pixel)
  );

  // An abort arriving during WRITE suppresses that cycle's write.
  always_comb begin
    busy      = (state == READ) || (state == WRITE);
    done      = (state == DONE);
    mem_addr  = cnt;
    mem_wen   = (state == WRITE) && !abort;
    mem_wdata = mem_wen ? xf_pixel : 12'h000;
  end

endmodule

// File: tb/tb_fb_filter_engine.sv
// Directed testbench for fb_filter_engine on a 4x2 frame with a
// synchronous-read RAM model.
module tb_fb_filter_engine;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;
  localparam int NP = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_rdata;
  logic [11:0]   mem_wdata;
  logic          mem_wen;

  logic [11:0]   ram [0:NP-1];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [11:0]   load_data;

  int n_cmp  = 0;
  int n_fail = 0;

  fb_filter_engine #(
    .WIDTH  (W),
    .HEIGHT (H),
    .ADDR_W (AW),
    .THRESH (23)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en)      ram[load_addr] <= load_data;
    else if (mem_wen) ram[mem_addr]  <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic [11:0] v);
    for (int i = 0; i < NP; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = v;
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic load_one(input int a, input logic [11:0] v);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Pulses start at the current negedge; returns the cycle index at which done
  // was seen (start cycle = 0), or 999 if it never came within the budget.
  task automatic run_frame(input logic [1:0] m, output int cyc);
    start = 1'b1;
    mode  = m;
    cyc   = 999;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  int         cyc;
  int         n_done;
  logic [11:0] gray_exp;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_wen",   32'(mem_wen),   32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Full frame invert: 3A5 -> C5A everywhere, done 17 cycles after start
    load_frame(12'h3A5);
    start = 1'b1; mode = 2'b01;
    @(negedge clk); start = 1'b0;
    check("inv_c1_busy", 32'(busy),     32'd1);
    check("inv_c1_wen",  32'(mem_wen),  32'd0);
    check("inv_c1_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("inv_c2_wen",   32'(mem_wen),   32'd1);
    check("inv_c2_wdata", 32'(mem_wdata), 32'hC5A);
    cyc = 999;
    for (int k = 3; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin cyc = k; break; end
    end
    check("inv_done_cyc", 32'(cyc),  32'd17);
    check("inv_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("inv_done_pulse", 32'(done), 32'd0);
    for (int i = 0; i < NP; i++) check($sformatf("inv_px%0d", i), 32'(ram[i]), 32'hC5A);

    // Threshold around THRESH=23
    load_frame(12'h000);
    load_one(0, 12'h777);
    load_one(1, 12'h888);
    run_frame(2'b10, cyc);
    check("thr_done_cyc", 32'(cyc),    32'd17);
    check("thr_777",      32'(ram[0]), 32'h000);
    check("thr_888",      32'(ram[1]), 32'hFFF);
    check("thr_000",      32'(ram[2]), 32'h000);

    // Mode 11
`ifdef FB_FILTER_GRAYSCALE_EN
    gray_exp = 12'h999;
`else
    gray_exp = 12'h4C8;
`endif
    load_frame(12'h4C8);
    run_frame(2'b11, cyc);
    check("gray_px0", 32'(ram[0]), 32'(gray_exp));
    check("gray_px7", 32'(ram[7]), 32'(gray_exp));

    // Abort during the WRITE of address 3 (cycle 8)
    load_frame(12'h3A5);
    start = 1'b1; mode = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    abort = 1'b1;
    #1;
    check("abt_addr", 32'(mem_addr), 32'd3);
    check("abt_wen",  32'(mem_wen),  32'd0);
    @(negedge clk);
    abort = 1'b0;
    check("abt_idle_busy", 32'(busy),     32'd0);
    check("abt_idle_addr", 32'(mem_addr), 32'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("abt_no_done", 32'(n_done), 32'd0);
    for (int i = 0; i < 3; i++)  check($sformatf("abt_px%0d", i), 32'(ram[i]), 32'hC5A);
    for (int i = 3; i < NP; i++) check($sformatf("abt_px%0d", i), 32'(ram[i]), 32'h3A5);

    // Abort together with start in IDLE, and abort alone in IDLE
    start = 1'b1; abort = 1'b1; mode = 2'b01;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abt_start_idle", 32'(busy), 32'd0);

    // Restart attempt and mode change mid-pass
    load_frame(12'h3A5);
    start = 1'b1; mode = 2'b01;
    cyc = 999;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) mode = 2'b00;
      if (done) begin cyc = k; break; end
    end
    start = 1'b0;
    check("mid_done_cyc", 32'(cyc), 32'd17);
    for (int i = 0; i < NP; i += 3) check($sformatf("mid_px%0d", i), 32'(ram[i]), 32'hC5A);
    check("mid_px7", 32'(ram[7]), 32'hC5A);

    // Reset asserted during the READ of address 5 (cycle 11)
    load_frame(12'h3A5);
    start = 1'b1; mode = 2'b01;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("mr_addr_pre", 32'(mem_addr), 32'd5);
    reset = 1'b0;
    #1;
    check("mr_busy",  32'(busy),      32'd0);
    check("mr_done",  32'(done),      32'd0);
    check("mr_wen",   32'(mem_wen),   32'd0);
    check("mr_addr",  32'(mem_addr),  32'd0);
    check("mr_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_px4", 32'(ram[4]), 32'hC5A);
    check("mr_px5", 32'(ram[5]), 32'h3A5);
    run_frame(2'b01, cyc);
    check("mr_rerun_cyc", 32'(cyc),    32'd17);
    check("mr_rerun_px0", 32'(ram[0]), 32'h3A5);
    check("mr_rerun_px5", 32'(ram[5]), 32'hC5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
